mem_req_arbiter: RTL

//  Round-robin arbiter sharing one 16x32 valid/ready memory slave among NUM_REQ requesters.

---
 rtl/mem_req_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one valid/ready memory slave among NUM_REQ requesters.
// The optional watchdog abort is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      up_req_i,
    input  logic [NUM_REQ-1:0]      up_rnw_i,
    input  logic [NUM_REQ*4-1:0]    up_addr_i,
    input  logic [NUM_REQ*32-1:0]   up_wdata_i,
    output logic [NUM_REQ-1:0]      up_ready_o,
    output logic [31:0]             up_rdata_o,
    output logic [2:0]              gnt_id_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    mem_req_o,
    output logic                    mem_rnw_o,
    output logic [3:0]              mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_ready_i,
    input  logic [31:0]             mem_rdata_i
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic [2:0]      win;
    logic [IW-1:0]   g;
    logic            busy, hs, abort, tmo;
    logic            sel_req, sel_rnw;
    logic [3:0]      sel_addr;
    logic [31:0]     sel_wdata;

    assign busy  = (state_q == BUSY);
    assign hs    = busy & mem_ready_i;
    assign abort = busy & ~mem_ready_i & ~sel_req;

    // live view of the granted requester's request fields
    always_comb begin
        g         = IW'(gnt_id_q);
        sel_req   = up_req_i[g];
        sel_rnw   = up_rnw_i[g];
        sel_addr  = up_addr_i[{g, 2'b00} +: 4];
        sel_wdata = up_wdata_i[{g, 5'b00000} +: 32];
    end

    // round-robin pick: lowest offset after rr_ptr wins, so scan far-to-near and let near overwrite
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (up_req_i[IW'(idx)]) win = 3'(idx);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [5:0] timer_q, timer_d;

    // timer counts cycles a grant has waited; held at zero while idle so every grant starts fresh
    always_comb timer_d = busy ? timer_q + 6'd1 : 6'd0;

    // watchdog timer register
    always_ff @(posedge clk) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end

    assign tmo = busy & ~mem_ready_i & sel_req & (timer_q == 6'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo        = 1'b0;
`endif

    // state, grant and priority pointer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 3'(NUM_REQ - 1);
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // next state: grant from IDLE, return to IDLE on handshake, abort or timeout
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        if (!busy) begin
            if (|up_req_i) begin
                state_d  = BUSY;
                gnt_id_d = win;
            end
        end else if (hs || abort || tmo) begin
            state_d  = IDLE;
            rr_ptr_d = (hs || tmo) ? gnt_id_q : rr_ptr_q;
        end
    end

    // outputs, forced to zero while reset is asserted
    always_comb begin
        busy_o      = reset & busy;
        mem_req_o   = busy_o;
        gnt_id_o    = reset ? gnt_id_q : 3'd0;
        mem_rnw_o   = busy_o & sel_rnw;
        mem_addr_o  = busy_o ? sel_addr : 4'd0;
        mem_wdata_o = busy_o ? sel_wdata : 32'd0;
        up_ready_o  = (reset & hs) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << g) : '0;
        up_rdata_o  = (reset & hs & sel_rnw) ? mem_rdata_i : 32'd0;
        err_o       = reset & tmo;
    end
endmodule
